// File: rtl/uni_s2b_pkg.sv
// rtl/uni_s2b_pkg.sv - shared state encoding and sizing constants for the unipolar stochastic-to-binary converter
package uni_s2b_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SKIP,
    ST_ACC,
    ST_DONE
  } state_e;

  localparam int DEF_INWD = 8;
  localparam int SKIP_CW  = 4;

endpackage

// File: rtl/uni_win_cnt.sv
// rtl/uni_win_cnt.sv - loadable up-counter with clear, enable and terminal-count flag
module uni_win_cnt #(
  parameter int             W      = 9,
  parameter logic [W-1:0]   TC_VAL = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (ld)
      cnt <= ld_val;
    else if (en)
      cnt <= cnt + 1'b1;
  end

  assign tc = (cnt == TC_VAL);

endmodule

// File: rtl/uni_s2b.sv
// rtl/uni_s2b.sv - counts ones of a unipolar bitstream over 2^INWD cycles and returns them as binary
// UNI_S2B_CONT_EN selects gap-free continuous windows with single-cycle oValid pulses.
module uni_s2b
  import uni_s2b_pkg::*;
#(
  parameter int INWD = DEF_INWD,
  parameter int SKIP = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            iStart,
  input  logic            iBit,
  output logic            oBusy,
  output logic            oValid,
  output logic [INWD-1:0] oVal
);

  localparam logic [INWD:0]        WIN_FULL  = {1'b1, {INWD{1'b0}}};
  localparam logic [INWD:0]        WIN_LAST  = {1'b0, {INWD{1'b1}}};
  localparam logic [SKIP_CW-1:0]   SKIP_LAST = SKIP_CW'(SKIP - 1);

  state_e             state_q, state_d;
  logic [SKIP_CW-1:0] skip_cnt;
  logic [INWD:0]      win_cnt, ones_cnt, ones_sum;
  logic               win_tc, ones_tc;
  logic               cnt_clr, fin, in_acc;

  assign in_acc   = (state_q == ST_ACC);
  assign ones_sum = ones_cnt + {{INWD{1'b0}}, iBit};

  uni_win_cnt #(.W(INWD + 1), .TC_VAL(WIN_FULL)) u_win (
    .clk(clk), .rst_n(rst_n), .clr(cnt_clr), .ld(1'b0), .ld_val('0),
    .en(in_acc), .cnt(win_cnt), .tc(win_tc)
  );

  uni_win_cnt #(.W(INWD + 1), .TC_VAL(WIN_FULL)) u_ones (
    .clk(clk), .rst_n(rst_n), .clr(cnt_clr), .ld(1'b0), .ld_val('0),
    .en(in_acc & iBit), .cnt(ones_cnt), .tc(ones_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  // A start always wins, including over the final sample of a window.
  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    fin     = 1'b0;
    if (iStart) begin
      state_d = (SKIP == 0) ? ST_ACC : ST_SKIP;
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        ST_SKIP: if (skip_cnt == SKIP_LAST) state_d = ST_ACC;
        ST_ACC: begin
          if ((win_cnt == WIN_LAST) || win_tc) begin
            fin = 1'b1;
`ifdef UNI_S2B_CONT_EN
            state_d = ST_ACC;
            cnt_clr = 1'b1;
`else
            state_d = ST_DONE;
`endif
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      skip_cnt <= '0;
    else if (iStart)
      skip_cnt <= '0;
    else if (state_q == ST_SKIP)
      skip_cnt <= skip_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oValid <= 1'b0;
      oVal   <= '0;
    end else begin
      if (iStart)
        oValid <= 1'b0;
      else if (fin)
        oValid <= 1'b1;
`ifdef UNI_S2B_CONT_EN
      else
        oValid <= 1'b0;
`endif
      // Last sample folds in here; a full window of ones saturates.
      if (fin)
        oVal <= (ones_tc || ones_sum[INWD]) ? {INWD{1'b1}} : ones_sum[INWD-1:0];
    end
  end

  assign oBusy = (state_q == ST_SKIP) || (state_q == ST_ACC);

endmodule
